// File: rtl/video_pkg.sv
// Shared types and constants for the video layer compositor.
// rgb_t is width-parameterised, so it is declared next to DATA_W inside the users.
package video_pkg;

    localparam int unsigned LAT_W      = 4;
    localparam int unsigned MAX_LAYERS = 8;

    typedef struct packed {
        logic hs;
        logic vs;
        logic ad;
        logic nf;
    } strobe_t;

    // Latency field idx of a packed LAT_W-per-layer table, layer 0 in the LSBs.
    function automatic int unsigned lat_of(input logic [MAX_LAYERS*LAT_W-1:0] lats,
                                           input int unsigned idx);
        return 32'(lats[idx*LAT_W +: LAT_W]);
    endfunction

endpackage

// File: rtl/video_layer_mux_if.sv
// Pixel-domain signal bundle of video_layer_mux: undelayed timing strobes,
// per-layer RGB, frame configuration inputs and the composited output.
interface video_layer_mux_if #(
    parameter int unsigned NUM_LAYERS = 2,
    parameter int unsigned DATA_W     = 8
);
    localparam int unsigned SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                           hs_in;
    logic                           vs_in;
    logic                           ad_in;
    logic                           nf_in;
    logic [NUM_LAYERS*3*DATA_W-1:0] layer_rgb_in;
    logic [SEL_W-1:0]               sel_in;
    logic                           key_mode_in;
    logic [3*DATA_W-1:0]            key_color_in;

    logic [3*DATA_W-1:0]            rgb_out;
    logic                           hs_out;
    logic                           vs_out;
    logic                           ad_out;
    logic                           nf_out;

    modport master (
        output hs_in, vs_in, ad_in, nf_in, layer_rgb_in, sel_in, key_mode_in, key_color_in,
        input  rgb_out, hs_out, vs_out, ad_out, nf_out
    );

    modport slave (
        input  hs_in, vs_in, ad_in, nf_in, layer_rgb_in, sel_in, key_mode_in, key_color_in,
        output rgb_out, hs_out, vs_out, ad_out, nf_out
    );

endinterface

// File: rtl/video_layer_mux_delay_line.sv
// Fixed-depth register delay line with asynchronous clear; DEPTH = 0 is a plain wire.
module delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign q_o = d_i;
    end else begin : g_regs
        logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                pipe_q <= '0;
            end else begin
                pipe_q[0] <= d_i;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign q_o = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/video_layer_mux.sv
// Frame-synchronous RGB layer compositor: realigns NUM_LAYERS streams and the timing
// strobes to MAX_LAT+1 cycles. Define VIDEO_LAYER_MUX_KEY_EN for colour-key overlay mode.
module video_layer_mux
    import video_pkg::*;
#(
    parameter int unsigned                  NUM_LAYERS = 2,
    parameter int unsigned                  DATA_W     = 8,
    parameter int unsigned                  MAX_LAT    = 4,
    parameter logic [NUM_LAYERS*LAT_W-1:0]  LAYER_LAT  = {4'd2, 4'd0}
) (
    input logic              clk_in,
    input logic              rst_n_in,
    video_layer_mux_if.slave vif
);

    localparam int unsigned SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned PIX_W = 3 * DATA_W;
    localparam logic [MAX_LAYERS*LAT_W-1:0] LAT_ALL = (MAX_LAYERS*LAT_W)'(LAYER_LAT);

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             key_mode;
        rgb_t             key;
    } cfg_t;

    localparam int unsigned CFG_W = $bits(cfg_t);

    cfg_t                  shadow_q, shadow_d, cfg_al;
    strobe_t               strb_in, strb_al, strb_q;
    rgb_t [NUM_LAYERS-1:0] pix_al;
    rgb_t                  rgb_d, rgb_q;

    assign strb_in = '{hs: vif.hs_in, vs: vif.vs_in, ad: vif.ad_in, nf: vif.nf_in};

    // Shadow reloads on nf_in; the combinational next value feeds the delay line so a
    // config presented alongside nf_in already governs that frame's first pixel.
    always_comb begin
        shadow_d = shadow_q;
        if (vif.nf_in) begin
            if ({{(32-SEL_W){1'b0}}, vif.sel_in} < NUM_LAYERS) begin
                shadow_d.sel = vif.sel_in;
            end
`ifdef VIDEO_LAYER_MUX_KEY_EN
            shadow_d.key_mode = vif.key_mode_in;
            shadow_d.key      = vif.key_color_in;
`endif
        end
    end

`ifndef VIDEO_LAYER_MUX_KEY_EN
    logic unused_key;
    assign unused_key = ^{vif.key_mode_in, vif.key_color_in, cfg_al.key_mode, cfg_al.key};
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    delay_line #(
        .WIDTH (CFG_W),
        .DEPTH (MAX_LAT)
    ) u_cfg_dly (
        .clk_i  (clk_in),
        .rst_ni (rst_n_in),
        .d_i    (shadow_d),
        .q_o    (cfg_al)
    );

    delay_line #(
        .WIDTH ($bits(strobe_t)),
        .DEPTH (MAX_LAT)
    ) u_strb_dly (
        .clk_i  (clk_in),
        .rst_ni (rst_n_in),
        .d_i    (strb_in),
        .q_o    (strb_al)
    );

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        localparam int unsigned LAT = lat_of(LAT_ALL, i);

        delay_line #(
            .WIDTH (PIX_W),
            .DEPTH (MAX_LAT - LAT)
        ) u_pix_dly (
            .clk_i  (clk_in),
            .rst_ni (rst_n_in),
            .d_i    (vif.layer_rgb_in[i*PIX_W +: PIX_W]),
            .q_o    (pix_al[i])
        );
    end

    always_comb begin
        rgb_d = pix_al[cfg_al.sel];
`ifdef VIDEO_LAYER_MUX_KEY_EN
        // Overlay: layer 0 is the backdrop, any higher non-keyed layer covers it.
        if (cfg_al.key_mode) begin
            rgb_d = pix_al[0];
            for (int unsigned i = 1; i < NUM_LAYERS; i++) begin
                if (pix_al[i] != cfg_al.key) begin
                    rgb_d = pix_al[i];
                end
            end
        end
`endif
        if (!strb_al.ad) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rgb_q  <= '0;
            strb_q <= '0;
        end else begin
            rgb_q  <= rgb_d;
            strb_q <= strb_al;
        end
    end

    assign vif.rgb_out = rgb_q;
    assign vif.hs_out  = strb_q.hs;
    assign vif.vs_out  = strb_q.vs;
    assign vif.ad_out  = strb_q.ad;
    assign vif.nf_out  = strb_q.nf;

endmodule

// File: tb/tb_video_layer_mux.sv
// Directed bench for video_layer_mux: steady-state vector table plus latency, ramp
// alignment, out-of-range select and asynchronous reset sequences.
module tb_video_layer_mux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    video_layer_mux_if #(.NUM_LAYERS(2), .DATA_W(8)) vif ();
    video_layer_mux_if #(.NUM_LAYERS(3), .DATA_W(8)) vif3 ();

    video_layer_mux #(
        .NUM_LAYERS (2),
        .DATA_W     (8),
        .MAX_LAT    (4),
        .LAYER_LAT  ({4'd2, 4'd0})
    ) u_dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .vif      (vif)
    );

    video_layer_mux #(
        .NUM_LAYERS (3),
        .DATA_W     (8),
        .MAX_LAT    (4),
        .LAYER_LAT  ({4'd1, 4'd2, 4'd0})
    ) u_dut3 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .vif      (vif3)
    );

    assign vif3.hs_in = vif.hs_in;
    assign vif3.vs_in = vif.vs_in;
    assign vif3.ad_in = vif.ad_in;
    assign vif3.nf_in = vif.nf_in;

    typedef struct {
        logic        hs, vs, ad, nf;
        logic [23:0] l0, l1;
        logic        sel, km;
        logic [23:0] key;
        logic [23:0] exp_sel;
        logic [23:0] exp_key;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hs, input logic vs, input logic ad, input logic nf,
                         input logic [23:0] l0, input logic [23:0] l1, input logic sel,
                         input logic km, input logic [23:0] key);
        vif.hs_in        = hs;
        vif.vs_in        = vs;
        vif.ad_in        = ad;
        vif.nf_in        = nf;
        vif.layer_rgb_in = {l1, l0};
        vif.sel_in       = sel;
        vif.key_mode_in  = km;
        vif.key_color_in = key;
    endtask

    function automatic logic [23:0] ramp(input int x);
        logic [7:0] b;
        b = 8'(x);
        return {b, b, b};
    endfunction

    initial begin
        logic [23:0] exp_rgb;
        logic        exp_ad;
        int          s;

        vecs[0]  = '{0, 0, 1, 1, 24'h112233, 24'hAABBCC, 1, 0, 24'h0, 24'hAABBCC, 24'hAABBCC};
        vecs[1]  = '{0, 0, 1, 1, 24'h112233, 24'hAABBCC, 0, 0, 24'h0, 24'h112233, 24'h112233};
        vecs[2]  = '{0, 0, 1, 0, 24'h112233, 24'hAABBCC, 1, 0, 24'h0, 24'h112233, 24'h112233};
        vecs[3]  = '{0, 0, 0, 0, 24'h112233, 24'hAABBCC, 1, 0, 24'h0, 24'h000000, 24'h000000};
        vecs[4]  = '{1, 1, 1, 1, 24'h112233, 24'hAABBCC, 1, 0, 24'h0, 24'hAABBCC, 24'hAABBCC};
        vecs[5]  = '{0, 0, 1, 1, 24'h123456, 24'h00FF00, 1, 1, 24'h00FF00, 24'h00FF00,
                     24'h123456};
        vecs[6]  = '{0, 0, 1, 0, 24'h123456, 24'hFF0000, 1, 1, 24'h00FF00, 24'hFF0000,
                     24'hFF0000};
        vecs[7]  = '{0, 0, 1, 0, 24'h00FF00, 24'h00FF00, 1, 1, 24'h00FF00, 24'h00FF00,
                     24'h00FF00};
        vecs[8]  = '{0, 0, 1, 1, 24'h00FF00, 24'hABCDEF, 0, 1, 24'h00FF00, 24'h00FF00,
                     24'hABCDEF};
        vecs[9]  = '{0, 0, 1, 1, 24'h123456, 24'h00FF00, 1, 0, 24'h00FF00, 24'h00FF00,
                     24'h00FF00};
        vecs[10] = '{0, 0, 0, 0, 24'h123456, 24'hABCDEF, 1, 1, 24'h00FF00, 24'h000000,
                     24'h000000};

        drive(0, 0, 0, 0, 24'h0, 24'h0, 0, 0, 24'h0);
        vif3.layer_rgb_in = {24'h333333, 24'h222222, 24'h111111};
        vif3.sel_in       = 2'd0;
        vif3.key_mode_in  = 1'b0;
        vif3.key_color_in = 24'h0;

        // Reset state.
        tick();
        tick();
        check("reset_rgb", 32'(vif.rgb_out), 32'h0);
        check("reset_strobes", {28'h0, vif.hs_out, vif.vs_out, vif.ad_out, vif.nf_out}, 32'h0);
        #3 rst_n = 1'b1;
        tick();

        // Steady-state vectors: optional nf cycle, then hold until aligned.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].hs, vecs[i].vs, vecs[i].ad, vecs[i].nf, vecs[i].l0, vecs[i].l1,
                  vecs[i].sel, vecs[i].km, vecs[i].key);
            tick();
            vif.nf_in = 1'b0;
            repeat (5) tick();
`ifdef VIDEO_LAYER_MUX_KEY_EN
            exp_rgb = vecs[i].exp_key;
`else
            exp_rgb = vecs[i].exp_sel;
`endif
            check($sformatf("vec%0d_rgb", i), 32'(vif.rgb_out), 32'(exp_rgb));
            check($sformatf("vec%0d_hs", i), 32'(vif.hs_out), 32'(vecs[i].hs));
            check($sformatf("vec%0d_vs", i), 32'(vif.vs_out), 32'(vecs[i].vs));
            check($sformatf("vec%0d_ad", i), 32'(vif.ad_out), 32'(vecs[i].ad));
            check($sformatf("vec%0d_nf", i), 32'(vif.nf_out), 32'h0);
        end

        // Single-cycle hs/vs/nf pulse appears exactly MAX_LAT+1 cycles later.
        drive(0, 0, 1, 1, 24'h112233, 24'hAABBCC, 1, 0, 24'h0);
        tick();
        vif.nf_in = 1'b0;
        repeat (6) tick();
        drive(1, 1, 1, 1, 24'h112233, 24'hAABBCC, 1, 0, 24'h0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            vif.hs_in = 1'b0;
            vif.vs_in = 1'b0;
            vif.nf_in = 1'b0;
            check($sformatf("pulse_hs_t%0d", k), 32'(vif.hs_out), 32'(k == 5));
            check($sformatf("pulse_vs_t%0d", k), 32'(vif.vs_out), 32'(k == 5));
            check($sformatf("pulse_nf_t%0d", k), 32'(vif.nf_out), 32'(k == 5));
        end

        // Ramp alignment: layer 1 trails its strobe by 2 cycles, layer 0 by 0.
        for (int sel = 0; sel < 2; sel++) begin
            for (int c = 0; c < 18; c++) begin
                drive(0, 0, (c >= 2 && c <= 11), (c == 0), ramp(c),
                      ramp(c - 2) ^ 24'hF00000, sel[0], 0, 24'h0);
                tick();
                s = c - 4;
                if (s >= 0) begin
                    exp_ad  = (s >= 2 && s <= 11);
                    exp_rgb = !exp_ad ? 24'h0 : (sel == 1) ? (ramp(s) ^ 24'hF00000) : ramp(s);
                    check($sformatf("ramp%0d_rgb_s%0d", sel, s), 32'(vif.rgb_out),
                          32'(exp_rgb));
                    check($sformatf("ramp%0d_ad_s%0d", sel, s), 32'(vif.ad_out), 32'(exp_ad));
                    check($sformatf("ramp%0d_nf_s%0d", sel, s), 32'(vif.nf_out), 32'(s == 0));
                end
            end
        end

        // Out-of-range select on the 3-layer instance keeps the previous choice.
        drive(0, 0, 1, 1, 24'h112233, 24'hAABBCC, 0, 0, 24'h0);
        vif3.sel_in = 2'd2;
        tick();
        vif.nf_in = 1'b0;
        repeat (5) tick();
        check("sel3_eq2", 32'(vif3.rgb_out), 32'h333333);
        vif.nf_in   = 1'b1;
        vif3.sel_in = 2'd3;
        tick();
        vif.nf_in = 1'b0;
        repeat (5) tick();
        check("sel3_oob_hold", 32'(vif3.rgb_out), 32'h333333);
        vif.nf_in   = 1'b1;
        vif3.sel_in = 2'd1;
        tick();
        vif.nf_in = 1'b0;
        repeat (5) tick();
        check("sel3_eq1", 32'(vif3.rgb_out), 32'h222222);

        // Asynchronous reset mid-line, then recovery with shadow sel back at 0.
        drive(0, 0, 1, 1, 24'h112233, 24'hAABBCC, 1, 0, 24'h0);
        tick();
        vif.nf_in = 1'b0;
        repeat (5) tick();
        check("prerst_rgb", 32'(vif.rgb_out), 32'hAABBCC);
        #3 rst_n = 1'b0;
        #1;
        check("rst_rgb_now", 32'(vif.rgb_out), 32'h0);
        check("rst_ad_now", 32'(vif.ad_out), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("rel_rgb_t%0d", k), 32'(vif.rgb_out),
                  (k == 5) ? 32'h112233 : 32'h0);
            check($sformatf("rel_ad_t%0d", k), 32'(vif.ad_out), 32'(k == 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
